mmx_wb_arbiter: RTL and testbench
=================================

# mmx_wb_arbiter

Shares the single write port of the MMX register file between two writeback producers: the MMX execute unit (requester 0) and the memory-load path (requester 1). It arbitrates round-robin and drives a registered writeback stage into the register file's writeback_data/select/enable inputs. It also keeps an 8-bit busy scoreboard so that decode can stall on read-after-write hazards. It sits between the execute/memory stages and the MMX register file in the writeback stage.

## Interface
Parameters:
- DATA_W, 64, writeback data width
- SEL_W, 3, register select width (8 registers MM0–MM7)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  execute unit has a result
- req0_sel  in  SEL_W  destination MMx
- req0_data  in  DATA_W  result
- req0_ready  out  1  req0 accepted this cycle
- req1_valid / req1_sel / req1_data / req1_ready  same as req0, for the load path
- reserve_valid  in  1  decode issues an instruction writing an MMx
- reserve_sel  in  SEL_W  register being reserved
- flush  in  1  pipeline flush; clears the scoreboard
- busy  out  8  bit i high = MMi has a pending write
- writeback_enable  out  1  to register file
- writeback_select  out  SEL_W  to register file
- writeback_data  out  DATA_W  to register file

## Operation
- Handshake: a transfer occurs on a rising edge where reqN_valid && reqN_ready. A requester holds valid, sel and data stable until the transfer. Valid must not depend on ready.
- Arbitration:
  - The write port accepts at most one request per cycle.
  - State is last_grant (1 bit). When both requesters are valid, grant the one that is not last_grant.
  - When only one is valid, grant it.
  - last_grant updates to the granted index on every transfer.
- reqN_ready is combinational from both valids and last_grant. It is forced low while flush=1.
- Writeback stage:
  - On a transfer, register sel/data into writeback_select/writeback_data and set writeback_enable=1.
  - With no transfer, writeback_enable=0 and sel/data hold their previous values.
  - There is no backpressure from the register file.
- Scoreboard (busy[7:0]):
  - Set: reserve_valid sets busy[reserve_sel] on the edge.
  - Clear: writeback_enable=1 clears busy[writeback_select] on the edge, i.e. the same edge the register file captures the data.
  - Same register set and cleared on one edge: the set wins, because a newer producer owns the register.
  - flush=1 clears all busy bits. A reserve in the same cycle as a flush is ignored.
  - A writeback already registered when flush arrives still completes.
- Both requesters targeting the same register in one cycle: arbitrate normally. The loser writes the next cycle, so the last write wins in grant order.
- No state machine beyond last_grant, the writeback register and busy.

## Timing
- Reset values: writeback_enable=0, writeback_select=0, writeback_data=0, busy=0, last_grant=1 (so req0 wins the first contested cycle). reqN_ready=0 while reset is high.
- Latency:
  - A transfer at edge N drives writeback_enable=1 from edge N to edge N+1.
  - The register file holds the value after edge N+1, which is also when the busy bit drops.
  - Consumers see busy low only once the data is readable.
- Sustained throughput is one writeback per cycle. With both valid every cycle, grants strictly alternate 0,1,0,1,…
- Reset asserted mid-operation: all outputs return to reset values asynchronously. The in-flight writeback is dropped and the scoreboard is cleared.

## Structure
- Shared package `mmx_pkg`: MMX_NUM_REGS=8, MMX_SEL_W=3, MMX_DATA_W=64, and the requester index constants REQ_EXEC=0 and REQ_LOAD=1.
- One natural sub-module: `rr_arbiter2`, a 2-input round-robin arbiter (valids, last_grant → grant one-hot) reused elsewhere.
- Scoreboard and writeback register stay in the top.
- Integration bench instantiates mmx_wb_arbiter driving mmx_register_file and checks mmN_out.

## Test plan
- Reset release with no valids → writeback_enable=0, busy=8'h00, both ready=0.
- reserve MM3 at edge 1; req0 {sel=3, data=64'h1234_5678_9abc_def0} transfers at edge 2 → busy=8'h08 after edge 1. writeback_enable=1 with that data after edge 2. mm3_out equals the data and busy=8'h00 after edge 3.
- Both valid continuously for 4 cycles (req0 sel=1, req1 sel=2) → grants 0,1,0,1. Each requester's ready toggles and writeback_select goes 1,2,1,2.
- Reserve MM5 on the same edge that a writeback of MM5 is enabled → busy[5] stays 1 after the edge.
- busy=8'hFF, then flush=1 with req0_valid=1 and reserve_valid=1 → req0_ready=0, busy=8'h00 next edge, no new writeback issued.
- Assert reset asynchronously mid-cycle while writeback_enable=1 and busy=8'h24 → all outputs return to zero immediately, with no register file write after that point.

Source files
------------

// File: rtl/mmx_pkg.sv
// Shared MMX writeback definitions: register file geometry and requester indices.
package mmx_pkg;

  localparam int unsigned MMX_NUM_REGS = 8;
  localparam int unsigned MMX_SEL_W    = 3;
  localparam int unsigned MMX_DATA_W   = 64;

  // Requester index on the shared writeback port.
  typedef enum logic {
    REQ_EXEC = 1'b0,
    REQ_LOAD = 1'b1
  } req_idx_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: grants the requester that did not win last time
// when both are valid, otherwise whichever one is valid.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant selection from the valids and the previous winner.
  always_comb begin
    grant    = '0;
    grant[0] = valid[0] & (~valid[1] | last_grant);
    grant[1] = valid[1] & (~valid[0] | ~last_grant);
  end

endmodule

// File: rtl/mmx_wb_arbiter.sv
// Shares the MMX register file write port between the execute unit and the
// load path, registers the winning writeback, and tracks pending writes in a
// per-register busy scoreboard for decode hazard stalls.
module mmx_wb_arbiter
  import mmx_pkg::*;
#(
  parameter int unsigned DATA_W = MMX_DATA_W,
  parameter int unsigned SEL_W  = MMX_SEL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              reserve_valid,
  input  logic [SEL_W-1:0]  reserve_sel,
  input  logic              flush,
  output logic [7:0]        busy,
  output logic              writeback_enable,
  output logic [SEL_W-1:0]  writeback_select,
  output logic [DATA_W-1:0] writeback_data
);

  req_idx_e                   last_grant_q, last_grant_d;
  logic                       wb_en_q, wb_en_d;
  logic [SEL_W-1:0]           wb_sel_q, wb_sel_d;
  logic [DATA_W-1:0]          wb_data_q, wb_data_d;
  logic [MMX_NUM_REGS-1:0]    busy_q, busy_d;

  logic [1:0] grant;
  logic [1:0] accept;
  logic       last_is_load;

  assign last_is_load = (last_grant_q == REQ_LOAD);

  rr_arbiter2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_is_load),
    .grant      (grant)
  );

  // Ready is the grant, suppressed during flush and while reset is held.
  always_comb begin
    accept     = grant & {2{~flush & ~reset}};
    req0_ready = accept[0];
    req1_ready = accept[1];
  end

  // Writeback register and round-robin pointer next-state.
  always_comb begin
    last_grant_d = last_grant_q;
    wb_en_d      = 1'b0;
    wb_sel_d     = wb_sel_q;
    wb_data_d    = wb_data_q;
    if (accept[1]) begin
      last_grant_d = REQ_LOAD;
      wb_en_d      = 1'b1;
      wb_sel_d     = req1_sel;
      wb_data_d    = req1_data;
    end else if (accept[0]) begin
      last_grant_d = REQ_EXEC;
      wb_en_d      = 1'b1;
      wb_sel_d     = req0_sel;
      wb_data_d    = req0_data;
    end
  end

  // Scoreboard next-state: clear on writeback first so a same-edge reserve wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wb_en_q)       busy_d[wb_sel_q]    = 1'b0;
      if (reserve_valid) busy_d[reserve_sel] = 1'b1;
    end
  end

  // State registers with asynchronous reset; in-flight writeback is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= REQ_LOAD;
      wb_en_q      <= 1'b0;
      wb_sel_q     <= '0;
      wb_data_q    <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wb_en_q      <= wb_en_d;
      wb_sel_q     <= wb_sel_d;
      wb_data_q    <= wb_data_d;
      busy_q       <= busy_d;
    end
  end

  // Drive the register file and decode from the registered state.
  always_comb begin
    writeback_enable = wb_en_q;
    writeback_select = wb_sel_q;
    writeback_data   = wb_data_q;
    busy             = busy_q;
  end

endmodule

// File: tb/tb_mmx_wb_arbiter.sv
// Directed bench for mmx_wb_arbiter with a behavioural register file model.
module tb_mmx_wb_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned SW = 3;

  logic          clk;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [SW-1:0] req0_sel, req1_sel;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          reserve_valid;
  logic [SW-1:0] reserve_sel;
  logic          flush;
  logic [7:0]    busy;
  logic          writeback_enable;
  logic [SW-1:0] writeback_select;
  logic [DW-1:0] writeback_data;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rf [8];

  localparam logic [DW-1:0] D_RAW  = 64'h1234_5678_9abc_def0;
  localparam logic [DW-1:0] D_EXEC = 64'hA0A0_0000_1111_0001;
  localparam logic [DW-1:0] D_LOAD = 64'hB1B1_0000_2222_0002;
  localparam logic [DW-1:0] D_FL   = 64'hC3C3_5555_6666_7777;
  localparam logic [DW-1:0] D_RST  = 64'hDEAD_BEEF_0BAD_F00D;

  mmx_wb_arbiter #(.DATA_W(DW), .SEL_W(SW)) dut (
    .clk              (clk),
    .reset            (reset),
    .req0_valid       (req0_valid),
    .req0_sel         (req0_sel),
    .req0_data        (req0_data),
    .req0_ready       (req0_ready),
    .req1_valid       (req1_valid),
    .req1_sel         (req1_sel),
    .req1_data        (req1_data),
    .req1_ready       (req1_ready),
    .reserve_valid    (reserve_valid),
    .reserve_sel      (reserve_sel),
    .flush            (flush),
    .busy             (busy),
    .writeback_enable (writeback_enable),
    .writeback_select (writeback_select),
    .writeback_data   (writeback_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file stand-in: captures on the edge where writeback_enable is high.
  always @(posedge clk) begin
    if (writeback_enable) rf[writeback_select] <= writeback_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    req0_valid = 0; req0_sel = '0; req0_data = '0;
    req1_valid = 0; req1_sel = '0; req1_data = '0;
    reserve_valid = 0; reserve_sel = '0; flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    idle_inputs();
    @(negedge clk);
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    req0_valid = 1;
    req1_valid = 1;
    #2;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_gated: got %b%b want 00", req1_ready, req0_ready);
    end
    idle_inputs();
    @(negedge clk);
    reset = 0;
    step();
    checks++;
    if (writeback_enable !== 1'b0 || busy !== 8'h00 || writeback_select !== 3'd0 ||
        writeback_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_state: got en=%b busy=%h sel=%0d data=%h want 0/00/0/0",
               writeback_enable, busy, writeback_select, writeback_data);
    end
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_ready: got %b%b want 00", req1_ready, req0_ready);
    end
  endtask

  task automatic test_raw_hazard();
    reserve_valid = 1; reserve_sel = 3;
    step();
    reserve_valid = 0;
    checks++;
    if (busy !== 8'h08) begin
      errors++;
      $display("FAIL raw_busy_set: got %h want 08", busy);
    end
    req0_valid = 1; req0_sel = 3; req0_data = D_RAW;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL raw_ready: got %b want 1", req0_ready);
    end
    step();
    req0_valid = 0;
    checks++;
    if (writeback_enable !== 1'b1 || writeback_select !== 3'd3 || writeback_data !== D_RAW ||
        busy !== 8'h08) begin
      errors++;
      $display("FAIL raw_wb_stage: got en=%b sel=%0d data=%h busy=%h want 1/3/%h/08",
               writeback_enable, writeback_select, writeback_data, busy, D_RAW);
    end
    step();
    checks++;
    if (rf[3] !== D_RAW || busy !== 8'h00 || writeback_enable !== 1'b0) begin
      errors++;
      $display("FAIL raw_complete: got mm3=%h busy=%h en=%b want %h/00/0",
               rf[3], busy, writeback_enable, D_RAW);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req0_valid = 1; req0_sel = 1; req0_data = D_EXEC;
    req1_valid = 1; req1_sel = 2; req1_data = D_LOAD;
    for (int i = 0; i < 4; i++) begin
      logic exp_load;
      exp_load = (i % 2) == 1;
      #1;
      checks++;
      if (req0_ready !== !exp_load || req1_ready !== exp_load) begin
        errors++;
        $display("FAIL alt_ready[%0d]: got r1r0=%b%b want %b%b",
                 i, req1_ready, req0_ready, exp_load, !exp_load);
      end
      step();
      checks++;
      if (writeback_enable !== 1'b1 || writeback_select !== (exp_load ? 3'd2 : 3'd1) ||
          writeback_data !== (exp_load ? D_LOAD : D_EXEC)) begin
        errors++;
        $display("FAIL alt_wb[%0d]: got en=%b sel=%0d data=%h want 1/%0d/%h", i,
                 writeback_enable, writeback_select, writeback_data,
                 exp_load ? 2 : 1, exp_load ? D_LOAD : D_EXEC);
      end
    end
    idle_inputs();
    step();
    checks++;
    if (rf[1] !== D_EXEC || rf[2] !== D_LOAD) begin
      errors++;
      $display("FAIL alt_rf: got mm1=%h mm2=%h want %h %h", rf[1], rf[2], D_EXEC, D_LOAD);
    end
  endtask

  task automatic test_set_wins();
    reserve_valid = 1; reserve_sel = 5;
    step();
    reserve_valid = 0;
    req1_valid = 1; req1_sel = 5; req1_data = D_LOAD;
    step();
    req1_valid = 0;
    reserve_valid = 1; reserve_sel = 5;
    step();
    reserve_valid = 0;
    checks++;
    if (busy !== 8'h20) begin
      errors++;
      $display("FAIL set_wins: got busy=%h want 20", busy);
    end
    step();
    checks++;
    if (busy !== 8'h20 || writeback_enable !== 1'b0) begin
      errors++;
      $display("FAIL set_wins_hold: got busy=%h en=%b want 20/0", busy, writeback_enable);
    end
  endtask

  task automatic test_flush();
    for (int r = 0; r < 8; r++) begin
      reserve_valid = 1; reserve_sel = r[SW-1:0];
      step();
    end
    reserve_valid = 0;
    checks++;
    if (busy !== 8'hFF) begin
      errors++;
      $display("FAIL flush_fill: got busy=%h want FF", busy);
    end
    flush = 1;
    req0_valid = 1; req0_sel = 4; req0_data = D_EXEC;
    reserve_valid = 1; reserve_sel = 7;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got r1r0=%b%b want 00", req1_ready, req0_ready);
    end
    step();
    idle_inputs();
    checks++;
    if (busy !== 8'h00 || writeback_enable !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: got busy=%h en=%b want 00/0", busy, writeback_enable);
    end
    // A writeback registered before the flush must still reach the register file.
    req0_valid = 1; req0_sel = 6; req0_data = D_FL;
    step();
    req0_valid = 0;
    flush = 1;
    step();
    flush = 0;
    checks++;
    if (rf[6] !== D_FL || busy !== 8'h00) begin
      errors++;
      $display("FAIL flush_inflight: got mm6=%h busy=%h want %h/00", rf[6], busy, D_FL);
    end
  endtask

  task automatic test_async_reset();
    reserve_valid = 1; reserve_sel = 2;
    step();
    reserve_sel = 5;
    req1_valid = 1; req1_sel = 2; req1_data = D_RST;
    step();
    idle_inputs();
    checks++;
    if (busy !== 8'h24 || writeback_enable !== 1'b1 || writeback_select !== 3'd2) begin
      errors++;
      $display("FAIL arst_setup: got busy=%h en=%b sel=%0d want 24/1/2",
               busy, writeback_enable, writeback_select);
    end
    req0_valid = 1;
    #1;
    reset = 1;
    #1;
    checks++;
    if (busy !== 8'h00 || writeback_enable !== 1'b0 || writeback_select !== 3'd0 ||
        writeback_data !== 64'd0 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL arst_outputs: got busy=%h en=%b sel=%0d data=%h r0=%b want all 0",
               busy, writeback_enable, writeback_select, writeback_data, req0_ready);
    end
    step();
    @(negedge clk);
    reset = 0;
    idle_inputs();
    step();
    checks++;
    if (rf[2] !== D_LOAD) begin
      errors++;
      $display("FAIL arst_dropped: got mm2=%h want %h", rf[2], D_LOAD);
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    for (int r = 0; r < 8; r++) rf[r] = '0;
    test_reset();
    test_raw_hazard();
    test_back_to_back();
    test_set_wins();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
